// File: rtl/digit_scan_controller.sv
// -----------------------------------------------------------------------------
// digit_scan_controller
//
// Time-multiplexed seven-segment display scanner. A snapshot of the packed
// digit values and the blanking mask is captured at the start of every frame.
// The scanner then steps through the digits, one slot per REFRESH_DIV clocks.
// For each slot it drives a one-hot digit select and the matching digit value.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (from the most significant digit down to
//   the first nonzero one) are also blanked. Digit 0 is never suppressed.
//   The suppression mask is captured together with the snapshot.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   reset      in   synchronous active-high reset
//   enable     in   1 = scan the display, 0 = display off
//   digits_in  in   NUM_DIGITS*DIGIT_W packed digit values, digit 0 in the LSBs
//   blank_mask in   per-digit force-dark mask
//   selector   out  one-hot select of the active digit, or all zeros
//   digit_out  out  value of the active digit (0 when dark)
//   digit_idx  out  index of the current slot
//   frame_done out  one-cycle pulse in the first cycle after a frame wrap
// -----------------------------------------------------------------------------
module digit_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_W     = 4,
    parameter int REFRESH_DIV = 4,
    parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [NUM_DIGITS-1:0]         selector,
    output logic [DIGIT_W-1:0]            digit_out,
    output logic [IDX_W-1:0]              digit_idx,
    output logic                          frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          frame_done_q, frame_done_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] snap_digits_q;
    logic [NUM_DIGITS-1:0]         snap_blank_q;
    logic                          load_snap;
    logic                          tick;
    logic                          last_digit;
    logic                          blanked;

    assign tick       = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = SCAN;
            SCAN:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Datapath next-state ----------------
    // Dropping enable wins over a pending tick: counters clear, no wrap pulse
    // and no snapshot reload happen on the way to IDLE.
    always_comb begin
        cnt_d        = '0;
        idx_d        = '0;
        frame_done_d = 1'b0;
        load_snap    = 1'b0;
        case (state_q)
            IDLE: begin
                load_snap = enable;
            end
            SCAN: begin
                if (enable) begin
                    if (tick) begin
                        cnt_d = '0;
                        if (last_digit) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                            load_snap    = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        idx_d = idx_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_done_q  <= 1'b0;
            snap_digits_q <= '0;
            snap_blank_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            if (load_snap) begin
                snap_digits_q <= digits_in;
                snap_blank_q  <= blank_mask;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Per-digit zero detect on the live inputs, evaluated at snapshot load.
    logic [NUM_DIGITS-1:0] digit_zero;
    logic [NUM_DIGITS-1:0] lz_d, lz_q;
    logic                  lz_run;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
        assign digit_zero[gi] = (digits_in[gi*DIGIT_W +: DIGIT_W] == '0);
    end

    // Suppression runs downward from the top digit and stops at the first
    // nonzero digit; digit 0 always stays visible.
    always_comb begin
        lz_d   = '0;
        lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run  = lz_run & digit_zero[i];
            lz_d[i] = lz_run;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lz_q <= '0;
        end else if (load_snap) begin
            lz_q <= lz_d;
        end
    end

    assign blanked = snap_blank_q[idx_q] | lz_q[idx_q];
`else
    assign blanked = snap_blank_q[idx_q];
`endif

    // ---------------- FSM: output decode ----------------
    always_comb begin
        selector  = '0;
        digit_out = '0;
        if (state_q == SCAN && !blanked) begin
            selector  = NUM_DIGITS'(1) << idx_q;
            digit_out = snap_digits_q[idx_q*DIGIT_W +: DIGIT_W];
        end
    end

    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// -----------------------------------------------------------------------------
// Directed testbench for digit_scan_controller (NUM_DIGITS=4, REFRESH_DIV=4).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, where they reflect the registered state of that edge.
// -----------------------------------------------------------------------------
module tb_digit_scan_controller;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int RD = 4;
    localparam int IW = 2;

    logic            clk;
    logic            reset;
    logic            enable;
    logic [ND*DW-1:0] digits_in;
    logic [ND-1:0]   blank_mask;
    logic [ND-1:0]   selector;
    logic [DW-1:0]   digit_out;
    logic [IW-1:0]   digit_idx;
    logic            frame_done;

    int checks = 0;
    int errors = 0;

    digit_scan_controller #(
        .NUM_DIGITS (ND),
        .DIGIT_W    (DW),
        .REFRESH_DIV(RD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .digits_in (digits_in),
        .blank_mask(blank_mask),
        .selector  (selector),
        .digit_out (digit_out),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // All four outputs checked against one expected tuple.
    task automatic check_all(input string tag, input logic [3:0] sel, input logic [3:0] dig,
                             input logic [1:0] idx, input logic fd);
        check({tag, ".selector"},   16'(selector),   16'(sel));
        check({tag, ".digit_out"},  16'(digit_out),  16'(dig));
        check({tag, ".digit_idx"},  16'(digit_idx),  16'(idx));
        check({tag, ".frame_done"}, 16'(frame_done), 16'(fd));
        $display("[%0t] %s sel=%b dig=%h idx=%0d fd=%b", $time, tag, selector, digit_out,
                 digit_idx, frame_done);
    endtask

    // Walk n cycles of a frame that started on the current sample point.
    // dig: hand-written expected snapshot, dark: hand-computed dark slots.
    // At cycle chg_at the live inputs are changed to chg_dig/chg_blank.
    task automatic check_frame(input string tag, input logic [15:0] dig, input logic [3:0] dark,
                               input logic fd_first, input int n, input int chg_at,
                               input logic [15:0] chg_dig, input logic [3:0] chg_blank);
        for (int c = 0; c < n; c++) begin
            int s;
            logic [3:0] esel;
            logic [3:0] edig;
            s = c / RD;
            if (c == chg_at) begin
                digits_in  = chg_dig;
                blank_mask = chg_blank;
            end
            esel = dark[s] ? 4'b0000 : (4'b0001 << s);
            edig = dark[s] ? 4'h0 : dig[s*4 +: 4];
            check_all($sformatf("%s.c%0d", tag, c), esel, edig, 2'(s), (c == 0) ? fd_first : 1'b0);
            step();
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        digits_in  = 16'h0000;
        blank_mask = 4'b0000;
        step();
        step();
        check_all("reset", 4'b0000, 4'h0, 2'd0, 1'b0);

        // Reset has priority over enable.
        enable    = 1'b1;
        digits_in = 16'h1234;
        step();
        check_all("reset_prio", 4'b0000, 4'h0, 2'd0, 1'b0);

        // First frame after leaving IDLE: no frame_done.
        reset = 1'b0;
        step();
        check_frame("f1", 16'h1234, 4'b0000, 1'b0, 16, -1, 16'h0, 4'b0);

        // Snapshot isolation: new digits during slot 1 only show next frame.
        check_frame("f2", 16'h1234, 4'b0000, 1'b1, 16, 5, 16'h5678, 4'b0000);
        check_frame("f3", 16'h5678, 4'b0000, 1'b1, 16, 5, 16'h1234, 4'b0100);

        // Blanking slot 2; frame length stays 16 (checked by f5 frame_done).
        check_frame("f4", 16'h1234, 4'b0100, 1'b1, 16, 3, 16'h1234, 4'b0000);

        // Disable during slot 2.
        check_frame("f5", 16'h1234, 4'b0000, 1'b1, 9, -1, 16'h0, 4'b0);
        enable = 1'b0;
        step();
        check_all("dis", 4'b0000, 4'h0, 2'd0, 1'b0);
        step();
        check_all("dis_hold", 4'b0000, 4'h0, 2'd0, 1'b0);

        // Re-enable: fresh snapshot, full slot 0, no frame_done.
        digits_in = 16'h9ABC;
        enable    = 1'b1;
        step();
        check_frame("re1", 16'h9ABC, 4'b0000, 1'b0, 16, -1, 16'h0, 4'b0);

        // Reset with enable held high mid-frame.
        check_frame("re2", 16'h9ABC, 4'b0000, 1'b1, 9, -1, 16'h0, 4'b0);
        reset = 1'b1;
        step();
        check_all("rst_mid", 4'b0000, 4'h0, 2'd0, 1'b0);
        reset = 1'b0;
        step();
        check_frame("rs1", 16'h9ABC, 4'b0000, 1'b0, 15, -1, 16'h0, 4'b0);

        // Drop enable on the last cycle of the frame: wrap must not pulse.
        enable = 1'b0;
        step();
        check_all("dis_wrap", 4'b0000, 4'h0, 2'd0, 1'b0);

        // Leading zeros.
        digits_in = 16'h0030;
        enable    = 1'b1;
        step();
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("lz30", 16'h0030, 4'b1100, 1'b0, 16, 0, 16'h0000, 4'b0000);
        check_frame("lz00", 16'h0000, 4'b1110, 1'b1, 16, -1, 16'h0, 4'b0);
`else
        check_frame("lz30", 16'h0030, 4'b0000, 1'b0, 16, 0, 16'h0000, 4'b0000);
        check_frame("lz00", 16'h0000, 4'b0000, 1'b1, 16, -1, 16'h0, 4'b0);
`endif
        check_all("lz_end", 4'b0001, 4'h0, 2'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
